// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and helpers for the PS/2 set-2 key encoder.
// Latency/backpressure: n/a (definitions only).
package ps2_pkg;
   localparam int PS2_KEY_W = 65;

   localparam logic [7:0] PS2_E0     = 8'hE0;
   localparam logic [7:0] PS2_F0     = 8'hF0;
   localparam logic [7:0] PS2_E1     = 8'hE1;
   localparam logic [7:0] PS2_PRN_12 = 8'h12;
   localparam logic [7:0] PS2_PRN_7C = 8'h7C;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PFX,
      ST_PAUSE,
      ST_PRN_MK,
      ST_PRN_BRK
   } ps2_enc_state_t;

   // True when 'code' appears in one of the prefix lanes [31:8] of an event word.
   function automatic logic prefix_has(input logic [63:0] dat, input logic [7:0] code);
      return (dat[15:8] == code) || (dat[23:16] == code) || (dat[31:24] == code);
   endfunction
endpackage

// File: rtl/ps2_key_encoder_if.sv
// Scancode byte feed in, toggle-stamped key events out.
// Latency/backpressure: n/a (signal bundle); the byte feed has no backpressure.
interface ps2_key_encoder_if;
   import ps2_pkg::*;

   logic [7:0]           byte_in;
   logic                 byte_valid;
   logic [PS2_KEY_W-1:0] ps2_key;
   logic                 key_stb;
   logic                 seq_err;

   modport master (output byte_in, byte_valid, input  ps2_key, key_stb, seq_err);
   modport slave  (input  byte_in, byte_valid, output ps2_key, key_stb, seq_err);
endinterface

// File: rtl/ps2_held_map.sv
// 512x1 held-key bitmap indexed by {extended, code}; built only with PS2_TYPEMATIC_FILTER_EN.
// Latency: combinational read, 1-cycle write; after reset a 512-cycle clearing sweep holds busy high.
`ifdef PS2_TYPEMATIC_FILTER_EN
module ps2_held_map (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic [8:0] rd_idx,
   output logic       rd_hit,
   input  logic       wr_en,
   input  logic [8:0] wr_idx,
   input  logic       wr_val,
   output logic       busy
);
   logic [511:0] map;
   logic [8:0]   swp_idx;
   logic         swp_on;

   // The map itself has no reset; it is cleared one bit per cycle instead.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         swp_idx <= '0;
         swp_on  <= 1'b1;
      end else if (swp_on) begin
         map[swp_idx] <= 1'b0;
         swp_idx      <= swp_idx + 9'd1;
         if (swp_idx == 9'd511)
            swp_on <= 1'b0;
      end else if (wr_en) begin
         map[wr_idx] <= wr_val;
      end
   end

   assign rd_hit = map[rd_idx];
   assign busy   = swp_on;
endmodule
`endif

// File: rtl/ps2_key_encoder.sv
// Assembles PS/2 set-2 bytes into 65-bit toggle-stamped events; optional typematic filter via PS2_TYPEMATIC_FILTER_EN.
// Latency: event registered 1 cycle after the final byte; backpressure: none, one byte per cycle accepted.
module ps2_key_encoder
   import ps2_pkg::*;
#(
   parameter logic [23:0] TIMEOUT_CYC = 24'd1_200_000
) (
   input  logic               clk_sys,
   input  logic               reset,
   ps2_key_encoder_if.slave   bus
);
   ps2_enc_state_t st, st_nx;
   logic [63:0] acc, acc_nx, sh, ev_dat, ev2_dat, pend_dat, out_dat;
   logic [3:0]  n, n_nx;
   logic [23:0] tmo;
   logic [7:0]  b;
   logic        is_pfx, ev_vld, ev_map, ev2_vld, err, clr;
   logic        pend_vld, pend_ld, keep, suppress, out_vld;
   logic [PS2_KEY_W-1:0] key_q;
   logic        stb_q, err_q;

   assign b      = bus.byte_in;
   assign sh     = {acc[55:0], b};
   assign is_pfx = (b == PS2_E0) || (b == PS2_F0);

   always_comb begin
      st_nx   = st;
      acc_nx  = acc;
      n_nx    = n;
      ev_vld  = 1'b0;
      ev_map  = 1'b0;
      ev_dat  = sh;
      ev2_vld = 1'b0;
      ev2_dat = {56'd0, b};
      err     = 1'b0;
      clr     = 1'b0;
      if (bus.byte_valid) begin
         case (st)
            ST_IDLE: begin
               if (is_pfx) begin
                  acc_nx = sh; n_nx = 4'd1; st_nx = ST_PFX;
               end else if (b == PS2_E1) begin
                  acc_nx = sh; n_nx = 4'd1; st_nx = ST_PAUSE;
               end else begin
                  ev_vld = 1'b1; ev_map = 1'b1;
               end
            end
            ST_PFX: begin
               if (is_pfx) begin
                  if (n < 4'd3) begin
                     acc_nx = sh; n_nx = n + 4'd1;
                  end else begin
                     err = 1'b1;
                  end
               end else if (n == 4'd1 && acc[7:0] == PS2_E0 && b == PS2_PRN_12) begin
                  acc_nx = sh; n_nx = 4'd2; st_nx = ST_PRN_MK;
               end else if (n == 4'd2 && acc[15:0] == {PS2_E0, PS2_F0} && b == PS2_PRN_7C) begin
                  acc_nx = sh; n_nx = 4'd3; st_nx = ST_PRN_BRK;
               end else begin
                  ev_vld = 1'b1; ev_map = 1'b1; clr = 1'b1;
               end
            end
            ST_PRN_MK: begin
               if (n == 4'd2 && b == PS2_E0) begin
                  acc_nx = sh; n_nx = 4'd3;
               end else if (n == 4'd3 && b == PS2_PRN_7C) begin
                  ev_vld = 1'b1; clr = 1'b1;
               end else begin
                  // Not a print-screen after all: flush E0 12, then treat this byte as a fresh start.
                  ev_vld = 1'b1;
                  ev_dat = {48'd0, PS2_E0, PS2_PRN_12};
                  if (is_pfx) begin
                     acc_nx = {56'd0, b}; n_nx = 4'd1; st_nx = ST_PFX;
                  end else if (b == PS2_E1) begin
                     acc_nx = {56'd0, b}; n_nx = 4'd1; st_nx = ST_PAUSE;
                  end else begin
                     ev2_vld = 1'b1; clr = 1'b1;
                  end
               end
            end
            ST_PRN_BRK: begin
               if ((n == 4'd3 && b == PS2_E0) || (n == 4'd4 && b == PS2_F0)) begin
                  acc_nx = sh; n_nx = n + 4'd1;
               end else if (n == 4'd5 && b == PS2_PRN_12) begin
                  ev_vld = 1'b1; clr = 1'b1;
               end else begin
                  err = 1'b1;
               end
            end
            ST_PAUSE: begin
               if (n == 4'd7) begin
                  ev_vld = 1'b1; clr = 1'b1;
               end else begin
                  acc_nx = sh; n_nx = n + 4'd1;
               end
            end
            default: err = 1'b1;
         endcase
      end else if (st != ST_IDLE && tmo == TIMEOUT_CYC - 24'd1) begin
         err = 1'b1;
      end
      if (err || clr) begin
         acc_nx = '0; n_nx = '0; st_nx = ST_IDLE;
      end
   end

`ifdef PS2_TYPEMATIC_FILTER_EN
   logic map_ext, map_brk, map_hit, map_busy;
   assign map_ext = prefix_has(ev_dat, PS2_E0);
   assign map_brk = prefix_has(ev_dat, PS2_F0);

   ps2_held_map u_held_map (
      .clk_sys (clk_sys),
      .reset   (reset),
      .rd_idx  ({map_ext, ev_dat[7:0]}),
      .rd_hit  (map_hit),
      .wr_en   (ev_vld & ev_map & ~map_busy),
      .wr_idx  ({map_ext, ev_dat[7:0]}),
      .wr_val  (~map_brk),
      .busy    (map_busy)
   );
   assign suppress = ~map_brk & map_hit & ~map_busy;
`else
   assign suppress = 1'b0;
`endif

   // A deferred event (from the print-screen fallback) goes out first; a new event behind it waits one cycle.
   assign keep    = ~(ev_map & suppress);
   assign out_vld = pend_vld | (ev_vld & keep);
   assign out_dat = pend_vld ? pend_dat : ev_dat;
   assign pend_ld = ev2_vld | (pend_vld & ev_vld & keep);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         st       <= ST_IDLE;
         acc      <= '0;
         n        <= '0;
         tmo      <= '0;
         pend_vld <= 1'b0;
         pend_dat <= '0;
         key_q    <= '0;
         stb_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         st    <= st_nx;
         acc   <= acc_nx;
         n     <= n_nx;
         stb_q <= out_vld;
         err_q <= err;
         if (bus.byte_valid || st == ST_IDLE || err)
            tmo <= '0;
         else
            tmo <= tmo + 24'd1;
         pend_vld <= pend_ld;
         if (pend_ld)
            pend_dat <= ev2_vld ? ev2_dat : ev_dat;
         if (out_vld)
            key_q <= {~key_q[64], out_dat};
      end
   end

   assign bus.ps2_key = key_q;
   assign bus.key_stb = stb_q;
   assign bus.seq_err = err_q;
endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed bench for ps2_key_encoder: framing, prefixes, PRNSCR/PAUSE, timeout, reset abort, typematic filter.
module tb_ps2_key_encoder;
   import ps2_pkg::*;

   localparam logic [23:0] TMO = 24'd40;

   logic        clk_sys = 1'b0;
   logic        reset;
   int          checks = 0;
   int          failures = 0;
   int          stb_cnt;
   int          k;
   logic [64:0] exp_key;
   logic [7:0]  pause_seq [8];
   logic [7:0]  brk_seq [6];

   ps2_key_encoder_if bus ();

   ps2_key_encoder #(.TIMEOUT_CYC(TMO)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] bv);
      bus.byte_in    = bv;
      bus.byte_valid = 1'b1;
      @(posedge clk_sys); #1;
      bus.byte_valid = 1'b0;
      stb_cnt += int'(bus.key_stb);
   endtask

   task automatic idle(input int c);
      repeat (c) @(posedge clk_sys);
      #1;
   endtask

   function automatic logic [64:0] nxt(input logic [64:0] prev, input logic [63:0] dat);
      return {~prev[64], dat};
   endfunction

   initial begin
      pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      brk_seq   = '{8'hE0, 8'hF0, 8'h7C, 8'hE0, 8'hF0, 8'h12};
      reset = 1'b1;
      bus.byte_in = 8'h00;
      bus.byte_valid = 1'b0;
      stb_cnt = 0;
      exp_key = '0;
      repeat (3) @(posedge clk_sys);
      #1;
      chk("rst_key", bus.ps2_key, 65'd0);
      chk("rst_stb", {64'd0, bus.key_stb}, 65'd0);
      chk("rst_err", {64'd0, bus.seq_err}, 65'd0);
      reset = 1'b0;
      idle(1);

      send(8'h1C);
      exp_key = nxt(exp_key, 64'h1C);
      chk("single_byte", bus.ps2_key, exp_key);
      chk("single_stb", {64'd0, bus.key_stb}, 65'd1);
      idle(1);
      chk("stb_one_cycle", {64'd0, bus.key_stb}, 65'd0);

      stb_cnt = 0;
      send(8'hE0);
      send(8'hF0);
      chk("prefix_no_event", bus.ps2_key, exp_key);
      send(8'h75);
      exp_key = nxt(exp_key, 64'hE0F075);
      chk("ext_break", bus.ps2_key, exp_key);
      chk("ext_break_stbs", 65'(stb_cnt), 65'd1);

      send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
      exp_key = nxt(exp_key, 64'hE012E07C);
      chk("prnscr_make", bus.ps2_key, exp_key);
      for (int i = 0; i < 6; i++) send(brk_seq[i]);
      exp_key = nxt(exp_key, 64'hE0F07CE0F012);
      chk("prnscr_break", bus.ps2_key, exp_key);

      stb_cnt = 0;
      for (int i = 0; i < 8; i++) send(pause_seq[i]);
      exp_key = nxt(exp_key, 64'hE11477E1F014F077);
      chk("pause", bus.ps2_key, exp_key);
      chk("pause_stbs", 65'(stb_cnt), 65'd1);

      send(8'h1C);
      exp_key = nxt(exp_key, 64'h1C);
      chk("b2b_first", bus.ps2_key, exp_key);
      send(8'h1D);
      exp_key = nxt(exp_key, 64'h1D);
      chk("b2b_second", bus.ps2_key, exp_key);
      idle(2);

      send(8'hF0);
      k = 0;
      while (bus.seq_err !== 1'b1 && k < int'(TMO) + 10) begin
         @(posedge clk_sys); #1;
         k++;
      end
      chk("timeout_cycles", 65'(k), 65'(TMO));
      chk("timeout_no_event", bus.ps2_key, exp_key);
      idle(1);
      chk("timeout_err_pulse", {64'd0, bus.seq_err}, 65'd0);
      send(8'h29);
      exp_key = nxt(exp_key, 64'h29);
      chk("after_timeout", bus.ps2_key, exp_key);

      send(8'hF0);
      idle(int'(TMO) - 1);
      send(8'h75);
      exp_key = nxt(exp_key, 64'hF075);
      chk("tie_byte_wins", bus.ps2_key, exp_key);
      chk("tie_no_err", {64'd0, bus.seq_err}, 65'd0);

      send(8'hE0); send(8'hE0); send(8'hE0); send(8'hE0);
      chk("malformed_err", {64'd0, bus.seq_err}, 65'd1);
      chk("malformed_no_event", bus.ps2_key, exp_key);
      send(8'h1C);
      exp_key = nxt(exp_key, 64'h1C);
      chk("after_malformed", bus.ps2_key, exp_key);

      send(8'hE0); send(8'h12); send(8'h1C);
      exp_key = nxt(exp_key, 64'hE012);
      chk("prn_mk_fallback", bus.ps2_key, exp_key);
      idle(1);
      exp_key = nxt(exp_key, 64'h1C);
      chk("prn_mk_replay", bus.ps2_key, exp_key);
      chk("prn_mk_replay_stb", {64'd0, bus.key_stb}, 65'd1);

      send(8'hE0); send(8'hF0); send(8'h7C); send(8'h33);
      chk("prn_brk_err", {64'd0, bus.seq_err}, 65'd1);
      chk("prn_brk_no_event", bus.ps2_key, exp_key);

      send(8'hE0);
      reset = 1'b1;
      @(posedge clk_sys); #1;
      reset = 1'b0;
      exp_key = '0;
      chk("midseq_reset_key", bus.ps2_key, exp_key);
      chk("midseq_reset_err", {64'd0, bus.seq_err}, 65'd0);
      send(8'h1C);
      exp_key = nxt(exp_key, 64'h1C);
      chk("after_reset", bus.ps2_key, exp_key);

      idle(520);
      stb_cnt = 0;
      send(8'h29);
      send(8'h29);
      send(8'hF0); send(8'h29);
      send(8'h29);
`ifdef PS2_TYPEMATIC_FILTER_EN
      chk("typematic_stbs", 65'(stb_cnt), 65'd3);
      chk("typematic_last", bus.ps2_key, {1'b0, 64'h29});
`else
      chk("typematic_stbs", 65'(stb_cnt), 65'd4);
      chk("typematic_last", bus.ps2_key, {1'b1, 64'h29});
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
